// File: rtl/fpu_esc_dispatch_pkg.sv
// Shared definitions for the ESC-to-FPU dispatcher: FSM encoding, queue entry
// layout and default sizing.
package fpu_esc_dispatch_pkg;

  localparam int DEFAULT_DEPTH   = 4;
  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DATA  = 2'd2
  } esc_state_t;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  modrm;
    logic        has_mem;
    logic [79:0] mem_data;
    logic [2:0]  mem_size;
  } esc_entry_t;

endpackage

// File: rtl/fpu_esc_dispatch_fifo.sv
// Parametric synchronous FIFO holding pending ESC instructions; the head entry
// is visible combinationally so the dispatcher can present it without delay.
module fpu_esc_fifo #(
  parameter int WIDTH = 100,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign rdata  = r_mem[r_rd_ptr];
  assign count  = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_esc_dispatch.sv
// Queues CPU ESC instructions and hands them to the FPU through an instruction
// handshake and an optional operand handshake, with timeout and overflow flags.
module fpu_esc_dispatch
  import fpu_esc_dispatch_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   esc_valid,
  input  logic [7:0]             esc_opcode,
  input  logic [7:0]             esc_modrm,
  input  logic                   esc_has_mem,
  input  logic [79:0]            esc_mem_data,
  input  logic [2:0]             esc_mem_size,
  output logic                   esc_ready,
  input  logic                   fwait_req,
  output logic                   fwait_done,
  output logic                   fpu_instr_valid,
  output logic [7:0]             fpu_opcode,
  output logic [7:0]             fpu_modrm,
  input  logic                   fpu_instr_ack,
  output logic                   fpu_data_write,
  output logic [2:0]             fpu_data_size,
  output logic [79:0]            fpu_data_out,
  input  logic                   fpu_data_ready,
  input  logic                   fpu_busy,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   err_overflow,
  output logic                   err_timeout,
  input  logic                   err_clr
);

  localparam int TW = $clog2(TIMEOUT + 1);

  esc_state_t       r_state;
  logic [TW-1:0]    r_wait_cnt;
  logic             r_instr_valid;
  logic [7:0]       r_opcode;
  logic [7:0]       r_modrm;
  logic             r_data_write;
  logic [79:0]      r_data;
  logic [2:0]       r_size;
  logic             r_fwait_done;
  logic             r_err_ovf;
  logic             r_err_tmo;

  esc_entry_t       w_wr_entry;
  esc_entry_t       w_head;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_expired;
  logic             w_tmo_set;
  logic [$clog2(DEPTH):0] w_count;

  assign w_wr_entry = '{opcode: esc_opcode, modrm: esc_modrm, has_mem: esc_has_mem,
                        mem_data: esc_mem_data, mem_size: esc_mem_size};
  assign w_push     = esc_valid && !w_full;
  assign w_expired  = (r_wait_cnt == TW'(TIMEOUT - 1));

  // Head leaves on a completed handshake or when its wait expires.
  assign w_tmo_set  = ((r_state == ST_ISSUE) && !fpu_instr_ack && w_expired) ||
                      ((r_state == ST_DATA)  && !fpu_data_ready && w_expired);
  assign w_pop      = ((r_state == ST_ISSUE) && fpu_instr_ack && !w_head.has_mem) ||
                      ((r_state == ST_DATA)  && fpu_data_ready) ||
                      w_tmo_set;

  fpu_esc_fifo #(
    .WIDTH ($bits(esc_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_wr_entry),
    .rdata (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_wait_cnt    <= '0;
      r_instr_valid <= 1'b0;
      r_opcode      <= '0;
      r_modrm       <= '0;
      r_data_write  <= 1'b0;
      r_data        <= '0;
      r_size        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty && !fpu_busy) begin
            r_state       <= ST_ISSUE;
            r_wait_cnt    <= '0;
            r_instr_valid <= 1'b1;
            r_opcode      <= w_head.opcode;
            r_modrm       <= w_head.modrm;
          end
        end
        ST_ISSUE: begin
          if (fpu_instr_ack || w_expired) begin
            r_instr_valid <= 1'b0;
            r_opcode      <= '0;
            r_modrm       <= '0;
            r_wait_cnt    <= '0;
            if (fpu_instr_ack && w_head.has_mem) begin
              r_state      <= ST_DATA;
              r_data_write <= 1'b1;
              r_data       <= w_head.mem_data;
              r_size       <= w_head.mem_size;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + TW'(1);
          end
        end
        ST_DATA: begin
          if (fpu_data_ready || w_expired) begin
            r_state      <= ST_IDLE;
            r_data_write <= 1'b0;
            r_data       <= '0;
            r_size       <= '0;
            r_wait_cnt   <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + TW'(1);
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_instr_valid <= 1'b0;
          r_data_write  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flags: a new event in the same cycle beats err_clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_ovf    <= 1'b0;
      r_err_tmo    <= 1'b0;
      r_fwait_done <= 1'b0;
    end else begin
      if (esc_valid && w_full) r_err_ovf <= 1'b1;
      else if (err_clr)        r_err_ovf <= 1'b0;
      if (w_tmo_set)           r_err_tmo <= 1'b1;
      else if (err_clr)        r_err_tmo <= 1'b0;
      r_fwait_done <= fwait_req && (w_count == '0) && (r_state == ST_IDLE) && !fpu_busy;
    end
  end

  assign esc_ready       = !w_full;
  assign q_count         = w_count;
  assign fpu_instr_valid = r_instr_valid;
  assign fpu_opcode      = r_opcode;
  assign fpu_modrm       = r_modrm;
  assign fpu_data_write  = r_data_write;
  assign fpu_data_out    = r_data;
  assign fpu_data_size   = r_size;
  assign fwait_done      = r_fwait_done;
  assign err_overflow    = r_err_ovf;
  assign err_timeout     = r_err_tmo;

endmodule

// File: tb/tb_fpu_esc_dispatch.sv
// Directed bench for fpu_esc_dispatch with a scoreboard of expected FPU
// handshakes checked by a negedge monitor.
module tb_fpu_esc_dispatch;

  logic        clk = 1'b0;
  logic        reset;
  logic        esc_valid;
  logic [7:0]  esc_opcode;
  logic [7:0]  esc_modrm;
  logic        esc_has_mem;
  logic [79:0] esc_mem_data;
  logic [2:0]  esc_mem_size;
  logic        esc_ready;
  logic        fwait_req;
  logic        fwait_done;
  logic        fpu_instr_valid;
  logic [7:0]  fpu_opcode;
  logic [7:0]  fpu_modrm;
  logic        fpu_instr_ack;
  logic        fpu_data_write;
  logic [2:0]  fpu_data_size;
  logic [79:0] fpu_data_out;
  logic        fpu_data_ready;
  logic        fpu_busy;
  logic [2:0]  q_count;
  logic        err_overflow;
  logic        err_timeout;
  logic        err_clr;

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  md;
    logic        hm;
    logic [79:0] data;
    logic [2:0]  size;
  } item_t;

  item_t sb[$];
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  fpu_esc_dispatch #(.DEPTH(4), .TIMEOUT(255)) dut (
    .clk             (clk),
    .reset           (reset),
    .esc_valid       (esc_valid),
    .esc_opcode      (esc_opcode),
    .esc_modrm       (esc_modrm),
    .esc_has_mem     (esc_has_mem),
    .esc_mem_data    (esc_mem_data),
    .esc_mem_size    (esc_mem_size),
    .esc_ready       (esc_ready),
    .fwait_req       (fwait_req),
    .fwait_done      (fwait_done),
    .fpu_instr_valid (fpu_instr_valid),
    .fpu_opcode      (fpu_opcode),
    .fpu_modrm       (fpu_modrm),
    .fpu_instr_ack   (fpu_instr_ack),
    .fpu_data_write  (fpu_data_write),
    .fpu_data_size   (fpu_data_size),
    .fpu_data_out    (fpu_data_out),
    .fpu_data_ready  (fpu_data_ready),
    .fpu_busy        (fpu_busy),
    .q_count         (q_count),
    .err_overflow    (err_overflow),
    .err_timeout     (err_timeout),
    .err_clr         (err_clr)
  );

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] op, input logic [7:0] md, input logic hm,
                      input logic [79:0] d, input logic [2:0] sz, input logic accept);
    esc_valid    = 1'b1;
    esc_opcode   = op;
    esc_modrm    = md;
    esc_has_mem  = hm;
    esc_mem_data = d;
    esc_mem_size = sz;
    chk("esc_ready", esc_ready, accept);
    if (accept) sb.push_back('{op, md, hm, d, sz});
    tick();
    esc_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!fpu_instr_valid && n < 50) begin
      tick();
      n++;
    end
    chk(tag, fpu_instr_valid, 1'b1);
  endtask

  task automatic serve_one();
    wait_valid("serve_valid");
    fpu_instr_ack = 1'b1;
    tick();
    fpu_instr_ack = 1'b0;
  endtask

  // Monitor: every completed FPU handshake must match the scoreboard head.
  always @(negedge clk) begin
    if (reset) begin
      if (fpu_instr_valid && fpu_instr_ack) begin
        if (sb.size() == 0) begin
          chk("instr_sb_empty", 1'b1, 1'b0);
        end else begin
          chk("instr_opcode", fpu_opcode, sb[0].op);
          chk("instr_modrm", fpu_modrm, sb[0].md);
          if (!sb[0].hm) void'(sb.pop_front());
        end
      end
      if (fpu_data_write && fpu_data_ready) begin
        if (sb.size() == 0) begin
          chk("data_sb_empty", 1'b1, 1'b0);
        end else begin
          item_t e;
          e = sb.pop_front();
          chk("data_out", fpu_data_out, e.data);
          chk("data_size", fpu_data_size, e.size);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; esc_valid = 1'b0; esc_opcode = '0; esc_modrm = '0;
    esc_has_mem = 1'b0; esc_mem_data = '0; esc_mem_size = '0; fwait_req = 1'b0;
    fpu_instr_ack = 1'b0; fpu_data_ready = 1'b0; fpu_busy = 1'b0; err_clr = 1'b0;
    tick(); tick();
    chk("rst_q_count", q_count, 0);
    chk("rst_instr_valid", fpu_instr_valid, 0);
    chk("rst_data_write", fpu_data_write, 0);
    chk("rst_errors", {err_overflow, err_timeout}, 0);
    reset = 1'b1;
    tick();
    chk("rst_esc_ready", esc_ready, 1);

    // Plain instruction, ack on the third valid cycle, then FWAIT retires.
    push(8'hD9, 8'hC1, 1'b0, '0, '0, 1'b1);
    chk("t1_q_count1", q_count, 1);
    chk("t1_valid_early", fpu_instr_valid, 0);
    tick();
    chk("t1_latency_valid", fpu_instr_valid, 1);
    chk("t1_opcode", fpu_opcode, 8'hD9);
    chk("t1_modrm", fpu_modrm, 8'hC1);
    tick();
    chk("t1_valid_c2", fpu_instr_valid, 1);
    tick();
    chk("t1_valid_c3", fpu_instr_valid, 1);
    fpu_instr_ack = 1'b1; fwait_req = 1'b1;
    tick();
    fpu_instr_ack = 1'b0;
    chk("t1_valid_drop", fpu_instr_valid, 0);
    chk("t1_opcode_zero", fpu_opcode, 0);
    chk("t1_q_count0", q_count, 0);
    chk("t1_fwait_pre", fwait_done, 0);
    tick();
    chk("t1_fwait_done", fwait_done, 1);
    fwait_req = 1'b0;
    tick();
    chk("t1_fwait_clear", fwait_done, 0);

    // Memory-operand instruction goes through the DATA handshake.
    push(8'hDD, 8'h06, 1'b1, 80'h4000_8000000000000000, 3'd3, 1'b1);
    wait_valid("t2_valid");
    chk("t2_data_idle", fpu_data_out, 0);
    fpu_instr_ack = 1'b1;
    tick();
    fpu_instr_ack = 1'b0;
    chk("t2_data_write", fpu_data_write, 1);
    chk("t2_data_out", fpu_data_out, 80'h4000_8000000000000000);
    chk("t2_data_size", fpu_data_size, 3);
    chk("t2_valid_off", fpu_instr_valid, 0);
    chk("t2_opcode_zero", fpu_opcode, 0);
    fwait_req = 1'b1;
    tick(); tick();
    chk("t2_data_hold", fpu_data_write, 1);
    chk("t2_fwait_busyq", fwait_done, 0);
    fpu_data_ready = 1'b1;
    tick();
    fpu_data_ready = 1'b0;
    chk("t2_write_drop", fpu_data_write, 0);
    chk("t2_data_zero", fpu_data_out, 0);
    chk("t2_size_zero", fpu_data_size, 0);
    chk("t2_q_count0", q_count, 0);
    tick();
    chk("t2_fwait_done", fwait_done, 1);
    fwait_req = 1'b0;

    // Fill while FPU is busy; fifth push overflows; clear loses to a new set.
    fpu_busy = 1'b1;
    for (int i = 0; i < 4; i++) push(8'hD8 + 8'(i), 8'h10 + 8'(i), 1'b0, '0, '0, 1'b1);
    chk("t3_full_ready", esc_ready, 0);
    chk("t3_q_count4", q_count, 4);
    chk("t3_ovf_pre", err_overflow, 0);
    push(8'hDF, 8'hFF, 1'b0, '0, '0, 1'b0);
    chk("t3_ovf_set", err_overflow, 1);
    chk("t3_q_count_hold", q_count, 4);
    err_clr = 1'b1;
    push(8'hDE, 8'hEE, 1'b0, '0, '0, 1'b0);
    err_clr = 1'b0;
    chk("t3_set_wins", err_overflow, 1);
    tick();
    chk("t3_busy_no_issue", fpu_instr_valid, 0);
    fpu_busy = 1'b0;
    for (int i = 0; i < 4; i++) serve_one();
    chk("t3_drained", q_count, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t3_ovf_clr", err_overflow, 0);

    // Never acknowledge: head dropped after TIMEOUT valid cycles.
    push(8'hD8, 8'h00, 1'b0, '0, '0, 1'b1);
    wait_valid("t4_valid");
    n = 0;
    while (fpu_instr_valid && n < 400) begin
      n++;
      tick();
    end
    chk("t4_valid_cycles", n, 255);
    chk("t4_q_count0", q_count, 0);
    chk("t4_err_timeout", err_timeout, 1);
    void'(sb.pop_front());
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_tmo_clr", err_timeout, 0);

    // Simultaneous push and pop at count 2, then pointer wrap traffic.
    fpu_busy = 1'b1;
    push(8'hD9, 8'hA0, 1'b0, '0, '0, 1'b1);
    push(8'hDA, 8'hA1, 1'b0, '0, '0, 1'b1);
    fpu_busy = 1'b0;
    wait_valid("t6_valid");
    chk("t6_q_count2_pre", q_count, 2);
    esc_valid = 1'b1; esc_opcode = 8'hDB; esc_modrm = 8'hA2; esc_has_mem = 1'b0;
    sb.push_back('{8'hDB, 8'hA2, 1'b0, 80'h0, 3'd0});
    fpu_instr_ack = 1'b1;
    tick();
    esc_valid = 1'b0; fpu_instr_ack = 1'b0;
    chk("t6_q_count2_post", q_count, 2);
    serve_one();
    serve_one();
    for (int i = 0; i < 5; i++) begin
      push(8'hD8 + 8'(i), 8'h30 + 8'(2 * i), 1'b0, '0, '0, 1'b1);
      push(8'hDC, 8'h31 + 8'(2 * i), 1'b0, '0, '0, 1'b1);
      serve_one();
      serve_one();
    end
    chk("t6_q_count0", q_count, 0);
    chk("sb_drained", sb.size(), 0);

    // Reset in the middle of a DATA handshake with a backlog and a sticky error.
    fpu_busy = 1'b1;
    push(8'hDD, 8'h46, 1'b1, 80'h1234_5678_9ABC_DEF0_1122, 3'd5, 1'b1);
    for (int i = 0; i < 3; i++) push(8'hD8, 8'h50 + 8'(i), 1'b0, '0, '0, 1'b1);
    push(8'hD8, 8'h5F, 1'b0, '0, '0, 1'b0);
    fpu_busy = 1'b0;
    wait_valid("t5_valid");
    fpu_instr_ack = 1'b1;
    tick();
    fpu_instr_ack = 1'b0;
    chk("t5_in_data", fpu_data_write, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_rst_write", fpu_data_write, 0);
    chk("t5_rst_data", fpu_data_out, 0);
    chk("t5_rst_valid", fpu_instr_valid, 0);
    chk("t5_rst_q_count", q_count, 0);
    chk("t5_rst_ovf", err_overflow, 0);
    sb.delete();
    tick();
    reset = 1'b1;
    tick();
    chk("t5_ready_after", esc_ready, 1);
    tick();
    chk("t5_idle_after", fpu_instr_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
